miss_mem_ctrl: RTL
==================

# miss_mem_ctrl

Main-memory stage directly downstream of the two-way cache. On a cache miss it takes one request. If the cache's victim line is dirty, it first writes that line back into a 32-entry backing store. It then reads the requested word and returns it to the cache with a one-cycle `done` pulse. A fixed, parameterised wait latency on every access models slow DRAM, so the cache's miss path exercises real stall behaviour.

## Interface
Parameters:
- `ADDR_W`, 5, address width; backing store depth is 2^ADDR_W.
- `DATA_W`, 8, word width.
- `LAT`, 3, cycles per memory access (write or read); legal range 1..15.

Ports:
- `clock`  in  1  single clock for all state, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  1  miss request; sampled only in IDLE.
- `wb`  in  1  victim is dirty; sampled with `req`.
- `wb_addr`  in  ADDR_W  victim address; sampled with `req`.
- `wb_data`  in  DATA_W  victim data; sampled with `req`.
- `rd_addr`  in  ADDR_W  missed address; sampled with `req`.
- `busy`  out  1  high whenever state is not IDLE; registered.
- `done`  out  1  one-cycle pulse: `rd_data` is valid.
- `rd_data`  out  DATA_W  fetched word; registered; held until the next fetch completes.
- `dbg_addr`  in  ADDR_W  debug read port address.
- `dbg_data`  out  DATA_W  combinational read of `mem[dbg_addr]`.

## Operation
- The backing store `mem[0..2^ADDR_W-1]` is registers, not an inferred RAM block.
- On reset, each entry initialises to its own index, zero-extended to DATA_W (`mem[i] = i`).
- FSM states: IDLE, WB, RD, DONE.
- IDLE:
  - `req`=1 latches `wb_addr`, `wb_data`, `rd_addr` and clears the wait counter.
  - Next state is WB if `wb`=1, otherwise RD.
  - `req`=0 stays in IDLE.
- WB:
  - The counter increments each cycle.
  - On the LAT-th edge in WB: `mem[wb_addr_q] <= wb_data_q`, counter clears, state goes to RD.
- RD:
  - The counter increments each cycle.
  - On the LAT-th edge in RD: `rd_data <= mem[rd_addr_q]`, `done <= 1`, state goes to DONE.
- DONE: next edge clears `done` and returns to IDLE. `req` is ignored in DONE.
- Read-after-writeback: the write completes before the read. If `wb_addr` equals `rd_addr`, `rd_data` returns `wb_data`.
- Changes on `req`, `wb` or any address/data input while `busy`=1 are ignored. Latched values are used throughout.
- `req` still high on the first IDLE cycle after DONE starts a new transaction. The cache must drop `req` on seeing `done`.
- `dbg_data` reflects a write from the cycle after the WB write edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rd_data`=0, counter 0, latched inputs 0, `mem[i]=i`.
- Reset asserted mid-transaction aborts immediately. A writeback not yet committed is lost, and no `done` is produced.
- Call the accept edge E0.
- Clean miss: `busy`=1 from E0 to E(LAT+1); `done`=1 in the cycle after E(LAT).
- Dirty miss: `busy`=1 from E0 to E(2·LAT+1); `done`=1 in the cycle after E(2·LAT); the memory write lands at E(LAT).
- Minimum request-to-request spacing: LAT+2 cycles clean, 2·LAT+2 cycles dirty.
- `done` is never high for more than one consecutive cycle.

## Test plan
All scenarios use LAT=3 unless stated.
- Reset: pulse `resetn` low, then release → `busy`=0, `done`=0, `rd_data`=0x00; `dbg_addr`=5 gives `dbg_data`=0x05.
- Clean miss: `req`=1, `wb`=0, `rd_addr`=9 for one cycle → `busy` high 4 cycles; `done` pulses 3 cycles after accept; `rd_data`=0x09.
- Dirty miss: `wb`=1, `wb_addr`=4, `wb_data`=0xA5, `rd_addr`=20 → `done` 6 cycles after accept; `rd_data`=0x14; `dbg_addr`=4 gives 0xA5.
- Same-address dirty miss: `wb_addr`=`rd_addr`=7, `wb_data`=0x3C → `rd_data`=0x3C.
- Toggle `req` and `rd_addr` while `busy`=1 → no extra `done`, result unchanged. Separately, assert `resetn` low at cycle 2 of a dirty miss to address 4 → `mem[4]`=0x04, `done` never pulses.
- LAT=1, `req` held high with `rd_addr`=1, then 2 → `done` every 3 cycles; `rd_data` 0x01, then 0x02.

Source files
------------

// File: rtl/miss_mem_ctrl_if.sv
// Miss-path bus between the two-way cache (master) and the main-memory
// stage (slave), plus the debug read port into the backing store.
interface miss_mem_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req;
    logic              wb;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output req, wb, wb_addr, wb_data, rd_addr, dbg_addr,
        input  busy, done, rd_data, dbg_data
    );

    modport slave (
        input  req, wb, wb_addr, wb_data, rd_addr, dbg_addr,
        output busy, done, rd_data, dbg_data
    );
endinterface

// File: rtl/miss_mem_ctrl.sv
// Main-memory stage behind the cache: optional dirty-victim writeback, then
// a word fetch, each access stalled for LAT cycles to model slow DRAM.
module miss_mem_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LAT    = 3
) (
    input  logic             clock,
    input  logic             resetn,
    miss_mem_ctrl_if.slave   bus
);
    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAST  = 4'(LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              w_accept;
    logic              w_mem_we;
    logic              w_rd_fire;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] w_mem [DEPTH];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_mem_we     = 1'b0;
        w_rd_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = 4'd0;
                    w_state_next = bus.wb ? S_WB : S_RD;
                end
            end
            S_WB: begin
                if (r_cnt == LAST) begin
                    w_mem_we     = 1'b1;
                    w_cnt_next   = 4'd0;
                    w_state_next = S_RD;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_RD: begin
                if (r_cnt == LAST) begin
                    w_rd_fire    = 1'b1;
                    w_cnt_next   = 4'd0;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_rd_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= w_mem[r_rd_addr];
            end
            if (w_accept) begin
                r_wb_addr <= bus.wb_addr;
                r_wb_data <= bus.wb_data;
                r_rd_addr <= bus.rd_addr;
            end
        end
    end

    // One register per word so reset can load every entry with its own index.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        logic [DATA_W-1:0] r_word;
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_word <= DATA_W'(gi);
            end else if (w_mem_we && (r_wb_addr == ADDR_W'(gi))) begin
                r_word <= r_wb_data;
            end
        end
        assign w_mem[gi] = r_word;
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_data  = r_rd_data;
    assign bus.dbg_data = w_mem[bus.dbg_addr];
endmodule
